// File: rtl/load_store_unit.sv
// RV32I load/store stage: captures an ALU-addressed access, runs a req/gnt/rvalid
// transaction to data memory and returns an extended load result or store completion.
module load_store_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_rd,
    output logic              resp_valid,
    output logic [4:0]        resp_rd,
    output logic [31:0]       resp_data,
    output logic              resp_err,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [4:0]        rd_q, rd_d;
    logic              err_q, err_d;
    logic [31:0]       data_q, data_d;

    logic              illegal;
    logic [1:0]        off;
    logic [31:0]       shifted;
    logic [31:0]       load_ext;
    logic [31:0]       st_wdata;
    logic [3:0]        st_be;

    // Decode legality directly from the request so errors bypass memory entirely.
    always_comb begin
        illegal = 1'b0;
        case (req_funct3)
            3'b000:  illegal = 1'b0;
            3'b001:  illegal = req_addr[0];
            3'b010:  illegal = |req_addr[1:0];
            3'b100:  illegal = req_we;
            3'b101:  illegal = req_we | req_addr[0];
            default: illegal = 1'b1;
        endcase
    end

    assign off     = addr_q[1:0];
    assign shifted = mem_rdata >> {off, 3'b000};

    always_comb begin
        load_ext = shifted;
        case (f3_q)
            3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_ext = {24'd0, shifted[7:0]};
            3'b101:  load_ext = {16'd0, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    always_comb begin
        st_wdata = wdata_q;
        st_be    = 4'b1111;
        if (we_q) begin
            case (f3_q[1:0])
                2'b00: begin
                    st_wdata = {4{wdata_q[7:0]}};
                    st_be    = 4'b0001 << off;
                end
                2'b01: begin
                    st_wdata = {2{wdata_q[15:0]}};
                    st_be    = 4'b0011 << off;
                end
                default: begin
                    st_wdata = wdata_q;
                    st_be    = 4'b1111;
                end
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        err_d   = err_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rd_d    = req_rd;
                    err_d   = illegal;
                    data_d  = 32'd0;
                    state_d = illegal ? RESP : REQ;
                end
            end
            REQ: begin
                if (mem_gnt) state_d = WAIT;
            end
            WAIT: begin
                if (mem_rvalid) begin
                    data_d  = we_q ? 32'd0 : load_ext;
                    state_d = RESP;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            rd_q    <= 5'd0;
            err_q   <= 1'b0;
            data_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
            data_q  <= data_d;
        end
    end

    // Memory and response buses read zero outside their own states.
    assign req_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign mem_req    = (state_q == REQ);
    assign mem_we     = mem_req & we_q;
    assign mem_addr   = mem_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign mem_be     = mem_req ? st_be : 4'd0;
    assign mem_wdata  = (mem_req && we_q) ? st_wdata : 32'd0;
    assign resp_valid = (state_q == RESP);
    assign resp_rd    = resp_valid ? rd_q : 5'd0;
    assign resp_data  = resp_valid ? data_q : 32'd0;
    assign resp_err   = resp_valid & err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and randomized bench for load_store_unit; expected values come from
// an arithmetic model of RV32I load/store semantics.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [4:0]  req_rd = 5'd0;
    logic        resp_valid;
    logic [4:0]  resp_rd;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    int checks = 0;
    int errors = 0;

    load_store_unit #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rd(req_rd),
        .resp_valid(resp_valid), .resp_rd(resp_rd), .resp_data(resp_data),
        .resp_err(resp_err), .busy(busy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned access_bytes(input logic [2:0] f3);
        case (f3[1:0])
            2'd0:    return 1;
            2'd1:    return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit model_err(input bit we, input logic [2:0] f3, input logic [31:0] a);
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b1;
        if (we && f3 > 3'b010) return 1'b1;
        return (a % access_bytes(f3)) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] word);
        int unsigned n = access_bytes(f3);
        logic [31:0] v = word >> (8 * (a % 4));
        logic [31:0] mask;
        if (n == 4) return v;
        mask = (32'd1 << (8 * n)) - 32'd1;
        v = v & mask;
        if (!f3[2] && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [3:0] model_be(input bit we, input logic [2:0] f3, input logic [31:0] a);
        int unsigned n = access_bytes(f3);
        if (!we) return 4'hF;
        return 4'(((32'd1 << n) - 32'd1) << (a % 4));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
        case (access_bytes(f3))
            1:       return {24'd0, wd[7:0]} * 32'h0101_0101;
            2:       return {16'd0, wd[15:0]} * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    // One full transaction, starting on the negedge where the request is presented.
    task automatic txn(input string tag, input bit we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                       input logic [31:0] word, input int gnt_dly, input int wait_dly);
        bit e = model_err(we, f3, a);
        @(negedge clk);
        chk({tag, ".ready"}, 32'(req_ready), 32'd1);
        chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a;
        req_wdata = wd; req_rd = rd;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = ~we; req_addr = $urandom; req_wdata = $urandom;
        req_rd = 5'($urandom); req_funct3 = 3'($urandom);
        if (!e) begin
            for (int i = 0; i <= gnt_dly; i++) begin
                @(negedge clk);
                chk({tag, ".mem_req"}, 32'(mem_req), 32'd1);
                chk({tag, ".mem_we"}, 32'(mem_we), 32'(we));
                chk({tag, ".mem_addr"}, mem_addr, a & ~32'd3);
                chk({tag, ".mem_be"}, 32'(mem_be), 32'(model_be(we, f3, a)));
                if (we) chk({tag, ".mem_wdata"}, mem_wdata, model_wdata(f3, wd));
                chk({tag, ".busy"}, 32'(busy), 32'd1);
                chk({tag, ".ready_busy"}, 32'(req_ready), 32'd0);
                mem_gnt = (i == gnt_dly);
                @(posedge clk); #1;
                mem_gnt = 1'b0;
            end
            for (int i = 0; i <= wait_dly; i++) begin
                @(negedge clk);
                chk({tag, ".wait_req"}, 32'(mem_req), 32'd0);
                chk({tag, ".wait_rv"}, 32'(resp_valid), 32'd0);
                if (i == wait_dly) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = word;
                end
                @(posedge clk); #1;
                mem_rvalid = 1'b0;
                mem_rdata  = $urandom;
            end
        end
        @(negedge clk);
        if (e) chk({tag, ".err_no_mem"}, 32'(mem_req), 32'd0);
        chk({tag, ".resp_valid"}, 32'(resp_valid), 32'd1);
        chk({tag, ".resp_err"}, 32'(resp_err), 32'(e));
        chk({tag, ".resp_data"}, resp_data, (e || we) ? 32'd0 : model_load(f3, a, word));
        chk({tag, ".resp_rd"}, 32'(resp_rd), 32'(rd));
        chk({tag, ".resp_ready"}, 32'(req_ready), 32'd0);
    endtask

    initial begin
        #2;
        chk("rst.ready", 32'(req_ready), 32'd1);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.mem_req", 32'(mem_req), 32'd0);
        chk("rst.mem_be", 32'(mem_be), 32'd0);
        chk("rst.mem_addr", mem_addr, 32'd0);
        chk("rst.resp_valid", 32'(resp_valid), 32'd0);
        chk("rst.resp_data", resp_data, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        txn("lb", 1'b0, 3'b000, 32'h0000_1003, 32'd0, 5'd7, 32'h80FF_1234, 0, 0);
        txn("sh", 1'b1, 3'b001, 32'h0000_2002, 32'hDEAD_BEEF, 5'd3, 32'h1234_5678, 0, 1);
        txn("lw_mis", 1'b0, 3'b010, 32'h0000_0006, 32'd0, 5'd9, 32'd0, 0, 0);
        txn("stall", 1'b1, 3'b000, 32'h0000_3001, 32'h0000_00A5, 5'd11, 32'd0, 5, 0);

        // Reset while waiting for rvalid, then a late rvalid must be ignored.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100; req_rd = 5'd4;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rstmid.mem_req", 32'(mem_req), 32'd1);
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstmid.mem_req_drop", 32'(mem_req), 32'd0);
        chk("rstmid.busy", 32'(busy), 32'd0);
        chk("rstmid.ready", 32'(req_ready), 32'd1);
        chk("rstmid.resp_valid", 32'(resp_valid), 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rstmid.late_rv", 32'(resp_valid), 32'd0);
            chk("rstmid.idle", 32'(busy), 32'd0);
        end
        txn("lbu", 1'b0, 3'b100, 32'h0000_0001, 32'd0, 5'd12, 32'h0000_8000, 0, 0);

        txn("ill_ld", 1'b0, 3'b011, 32'h0000_0040, 32'd0, 5'd13, 32'd0, 0, 0);
        txn("ill_st", 1'b1, 3'b100, 32'h0000_0040, 32'h1111_2222, 5'd14, 32'd0, 0, 0);

        for (int k = 0; k < 40; k++) begin
            txn("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                32'h0000_4000 + 32'($urandom_range(0, 63)), $urandom,
                5'($urandom_range(0, 31)), $urandom,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end

        @(negedge clk);
        chk("end.ready", 32'(req_ready), 32'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
